front_panel_led_integrator: RTL
===============================

Name: front_panel_led_integrator

Overview:
- Upstream feeder for the VGA front-panel renderer.
- Watches the raw CPU bus/status lines every clock and measures the duty cycle of each of the 36 panel LEDs over one video frame.
- At the start of each vertical sync, latches a stable on/off value per LED. Fast-toggling bus bits therefore render like real incandescent/LED persistence, and the display never tears mid-frame.
- Outputs drive the renderer's addrLEDs/dataLEDs/statusLEDs/otherLEDs inputs directly.

Parameters:
- CW, 20, width of every per-LED on-counter and of the window sample counter; all counters saturate.
- THRESH_SHIFT, 2, LED is lit iff on_count >= (total >> THRESH_SHIFT) and on_count != 0 (default threshold: 25% duty).

Ports:
- clk  input  1  system/pixel clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sample_en  input  1  qualifies a bus sample (e.g. CPU cycle strobe); counters advance only when 1.
- addr_in  input  16  raw address bus.
- data_in  input  8  raw data bus.
- status_in  input  8  raw status byte.
- other_in  input  4  INTE/PROT/WAIT/HLDA raw lines.
- frame_vs  input  1  renderer's vga_hs/vs-style active-low vertical sync.
- addrLEDs  output  16  latched address LED states.
- dataLEDs  output  8  latched data LED states.
- statusLEDs  output  8  latched status LED states.
- otherLEDs  output  4  latched other LED states.
- frame_tick  output  1  one-cycle pulse on the cycle the LED outputs update.

Behaviour:
- Reset (reset=0, async): all LED outputs 0, frame_tick 0, all counters 0, vs_prev register 1. Reset takes effect immediately, including mid-window.
- Edge detect: vs_prev <= frame_vs every cycle. window_end = vs_prev & ~frame_vs, i.e. a falling edge of frame_vs. frame_vs is in the clk domain, so no synchroniser is used.
- Per-LED on-counter k (36 total) and total counter; normal cycle (window_end=0):
  - If sample_en=1 and total != 2^CW-1: total += 1, and on_k += bit_k for every LED.
  - If total is saturated, no counter changes (window frozen, ratios preserved).
  - If sample_en=0, all counters hold.
- On a window_end cycle:
  - If total != 0, every LED output is updated from the registered counter values: LED_k <= (on_k != 0) && (on_k >= total >> THRESH_SHIFT).
  - If total == 0 (no samples in the window), all LED outputs hold their previous values.
  - frame_tick <= 1 in either case, for one cycle.
  - On the same cycle counters restart with the current sample: total <= sample_en, on_k <= sample_en & bit_k. A sample coincident with the edge belongs to the new window.
- Latency: LED outputs and frame_tick are registered and become valid one clk after the cycle in which frame_vs is first observed low.
- Comparisons are unsigned CW-bit. The shift is logical. No multipliers.
- Back-to-back edges (frame_vs toggling every cycle) are legal. Each falling edge closes a window.
- Outputs change only on window_end or reset. They are stable for a full frame otherwise.

Test Plan:
- Reset: hold reset=0 with arbitrary inputs and sample_en=1 -> all LED outputs 0, frame_tick 0. Release, no vs edge -> outputs remain 0.
- Steady bus: addr_in=16'h1234, data_in=8'hA5, status_in=8'h02, other_in=4'h9, sample_en=1 for 1000 cycles, then frame_vs 1->0 -> one cycle later addrLEDs=16'h1234, dataLEDs=8'hA5, statusLEDs=8'h02, otherLEDs=4'h9, frame_tick=1 for exactly 1 cycle.
- Duty threshold (THRESH_SHIFT=2), 800 samples per window:
  - addr_in[0] high for 200 samples -> addrLEDs[0]=1.
  - Next window, 199 samples -> addrLEDs[0]=0.
  - Next window, 0 samples -> addrLEDs[0]=0.
- Empty window: after a window leaves dataLEDs=8'hA5, run a full window with sample_en=0, then a vs edge -> dataLEDs stays 8'hA5 and frame_tick still pulses.
- Saturation (CW=4): 20 samples with status_in[7]=1 on samples 1-10 only -> total freezes at 15, on=10 -> statusLEDs[7]=1. Samples 16-20 are verified ignored.
- Edge-coincident sample and async reset:
  - Sample with addr_in[15]=1 exactly on the edge cycle, then only addr_in[15]=0 samples for 3 more samples -> next window total=4, on=1 -> addrLEDs[15]=1.
  - Assert reset mid-window -> outputs 0 within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/front_panel_led_integrator.sv
// Per-frame duty-cycle integrator for the 36 front-panel LEDs; latches a stable
// on/off state per LED at each falling edge of the renderer's vertical sync.
module front_panel_led_integrator #(
  parameter int CW           = 20,
  parameter int THRESH_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [15:0] addr_in,
  input  logic [7:0]  data_in,
  input  logic [7:0]  status_in,
  input  logic [3:0]  other_in,
  input  logic        frame_vs,
  output logic [15:0] addrLEDs,
  output logic [7:0]  dataLEDs,
  output logic [7:0]  statusLEDs,
  output logic [3:0]  otherLEDs,
  output logic        frame_tick
);

  localparam int N = 36;

  logic [N-1:0]  w_bits;
  logic [N-1:0]  w_lit;
  logic          w_window_end;
  logic          w_total_sat;
  logic          w_advance;
  logic [CW-1:0] w_thresh;

  logic          r_vs_prev;
  logic [CW-1:0] r_total;
  logic [N-1:0]  r_leds;
  logic          r_frame_tick;

  assign w_bits       = {other_in, status_in, data_in, addr_in};
  assign w_window_end = r_vs_prev & ~frame_vs;
  assign w_total_sat  = &r_total;
  // Once the window counter saturates every counter freezes, so ratios survive.
  assign w_advance    = sample_en & ~w_total_sat;
  assign w_thresh     = r_total >> THRESH_SHIFT;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_led
      logic [CW-1:0] r_on;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_on <= '0;
        end else if (w_window_end) begin
          r_on <= {{(CW-1){1'b0}}, sample_en & w_bits[gi]};
        end else if (w_advance) begin
          r_on <= r_on + CW'(w_bits[gi]);
        end
      end

      assign w_lit[gi] = (r_on != '0) && (r_on >= w_thresh);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vs_prev    <= 1'b1;
      r_total      <= '0;
      r_leds       <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_vs_prev    <= frame_vs;
      r_frame_tick <= w_window_end;
      if (w_window_end) begin
        // An empty window carries no information, so the panel keeps its last image.
        if (r_total != '0) begin
          r_leds <= w_lit;
        end
        r_total <= {{(CW-1){1'b0}}, sample_en};
      end else if (w_advance) begin
        r_total <= r_total + 1'b1;
      end
    end
  end

  assign addrLEDs   = r_leds[15:0];
  assign dataLEDs   = r_leds[23:16];
  assign statusLEDs = r_leds[31:24];
  assign otherLEDs  = r_leds[35:32];
  assign frame_tick = r_frame_tick;

endmodule
